// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice allocator: voice/allocator state encodings,
// port widths, and the top-octave frequency table (MIDI notes 120..131, Q14.4 Hz, truncated).
package synth_pkg;

    localparam int FREQ_W = 18;
    localparam int VOL_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } voice_state_e;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        SEARCH = 2'd1,
        APPLY  = 2'd2
    } alloc_state_e;

    // C9 .. B9; lower octaves are obtained by right-shifting these.
    localparam logic [FREQ_W-1:0] BASE_FREQ [12] = '{
        18'd133952, 18'd141917, 18'd150356, 18'd159297,
        18'd168769, 18'd178804, 18'd189437, 18'd200701,
        18'd212636, 18'd225280, 18'd238675, 18'd252868
    };

endpackage

// File: rtl/note_to_freq.sv
// Combinational MIDI note -> Q14.4 frequency: octave/semitone split, table lookup, shift down.
// Zero latency, no handshake.
module note_to_freq
    import synth_pkg::*;
(
    input  logic [6:0]        note_i,
    output logic [FREQ_W-1:0] freq_o
);

    logic [3:0] oct;
    logic [3:0] semi;
    logic [3:0] shamt;

    always_comb begin
        oct    = 4'(note_i / 7'd12);
        semi   = 4'(note_i % 7'd12);
        shamt  = 4'd10 - oct;
        freq_o = BASE_FREQ[semi] >> shamt;
    end

endmodule

// File: rtl/synth_voice_allocator.sv
// Note-event voice allocator with per-voice attack/sustain/release volume ramps.
// Event applied 2 cycles after handshake; ev_ready low for the 2 cycles following an accept.
module synth_voice_allocator
    import synth_pkg::*;
#(
    parameter int VOICES       = 4,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic                     ev_note_on,
    input  logic [6:0]               ev_note,
    input  logic [6:0]               ev_velocity,
    input  logic                     env_tick,
    output logic [VOICES*FREQ_W-1:0] frequencies,
    output logic [VOICES*VOL_W-1:0]  voice_volumes,
    output logic [VOICES-1:0]        voice_active
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    alloc_state_e     alloc_q, alloc_d;
    logic             live_q;
    logic             ev_on_q, ev_on_d;
    logic [6:0]       ev_note_q, ev_note_d;
    logic [VOL_W-1:0] ev_tgt_q, ev_tgt_d;
    logic             hit_q, hit_d;
    logic             retrig_q, retrig_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [6:0]        note_q [VOICES];
    logic [6:0]        note_d [VOICES];
    voice_state_e      st_q   [VOICES];
    voice_state_e      st_d   [VOICES];
    logic [VOL_W-1:0]  vol_q  [VOICES];
    logic [VOL_W-1:0]  vol_d  [VOICES];
    logic [VOL_W-1:0]  tgt_q  [VOICES];
    logic [VOL_W-1:0]  tgt_d  [VOICES];
    logic [7:0]        age_q  [VOICES];
    logic [7:0]        age_d  [VOICES];
    logic [FREQ_W-1:0] freq_q [VOICES];
    logic [FREQ_W-1:0] freq_d [VOICES];

    logic [FREQ_W-1:0] new_freq;

    logic             same_fnd, idle_fnd, off_fnd;
    logic [IDX_W-1:0] same_idx, idle_idx, off_idx, old_idx;
    logic [7:0]       old_age;

    note_to_freq u_note_to_freq (
        .note_i (ev_note_q),
        .freq_o (new_freq)
    );

    // live_q keeps ev_ready low through reset and for no longer than the first edge after it.
    assign ev_ready = live_q && (alloc_q == ACCEPT);

    always_comb begin
        alloc_d   = alloc_q;
        ev_on_d   = ev_on_q;
        ev_note_d = ev_note_q;
        ev_tgt_d  = ev_tgt_q;
        case (alloc_q)
            ACCEPT: begin
                if (ev_valid && ev_ready) begin
                    ev_on_d   = ev_note_on && (ev_velocity != 7'd0);
                    ev_note_d = ev_note;
                    ev_tgt_d  = {ev_velocity, 1'b0};
                    alloc_d   = SEARCH;
                end
            end
            SEARCH:  alloc_d = APPLY;
            default: alloc_d = ACCEPT;
        endcase
    end

    // Descending scans let the lowest matching index win; the age scan uses a strict compare
    // so ties also resolve to the lowest index.
    always_comb begin
        same_fnd = 1'b0;
        idle_fnd = 1'b0;
        off_fnd  = 1'b0;
        same_idx = '0;
        idle_idx = '0;
        off_idx  = '0;
        old_idx  = '0;
        old_age  = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (st_q[v] != IDLE && note_q[v] == ev_note_q) begin
                same_fnd = 1'b1;
                same_idx = IDX_W'(v);
            end
            if (st_q[v] == IDLE) begin
                idle_fnd = 1'b1;
                idle_idx = IDX_W'(v);
            end
            if ((st_q[v] == ATTACK || st_q[v] == SUSTAIN) && note_q[v] == ev_note_q) begin
                off_fnd = 1'b1;
                off_idx = IDX_W'(v);
            end
        end
        for (int v = 0; v < VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_age = age_q[v];
                old_idx = IDX_W'(v);
            end
        end

        hit_d    = hit_q;
        retrig_d = retrig_q;
        idx_d    = idx_q;
        if (alloc_q == SEARCH) begin
            if (ev_on_q) begin
                hit_d    = 1'b1;
                retrig_d = same_fnd;
                idx_d    = same_fnd ? same_idx : (idle_fnd ? idle_idx : old_idx);
            end else begin
                hit_d    = off_fnd;
                retrig_d = 1'b0;
                idx_d    = off_idx;
            end
        end
    end

    // Envelope step first, then APPLY overrides the selected voice so its tick is dropped.
    always_comb begin
        note_d = note_q;
        st_d   = st_q;
        vol_d  = vol_q;
        tgt_d  = tgt_q;
        age_d  = age_q;
        freq_d = freq_q;
        for (int v = 0; v < VOICES; v++) begin
            if (env_tick) begin
                case (st_q[v])
                    ATTACK: begin
                        if ({1'b0, vol_q[v]} + 9'(ATTACK_STEP) >= {1'b0, tgt_q[v]}) begin
                            vol_d[v] = tgt_q[v];
                            st_d[v]  = SUSTAIN;
                        end else begin
                            vol_d[v] = vol_q[v] + VOL_W'(ATTACK_STEP);
                        end
                    end
                    RELEASE: begin
                        if ({1'b0, vol_q[v]} <= 9'(RELEASE_STEP)) begin
                            vol_d[v] = '0;
                            st_d[v]  = IDLE;
                        end else begin
                            vol_d[v] = vol_q[v] - VOL_W'(RELEASE_STEP);
                        end
                    end
                    default: ;
                endcase
            end
            if (alloc_q == APPLY && hit_q) begin
                if (IDX_W'(v) == idx_q) begin
                    if (ev_on_q) begin
                        note_d[v] = ev_note_q;
                        tgt_d[v]  = ev_tgt_q;
                        st_d[v]   = ATTACK;
                        age_d[v]  = '0;
                        freq_d[v] = new_freq;
                        vol_d[v]  = retrig_q ? vol_q[v] : '0;
                    end else begin
                        st_d[v]   = RELEASE;
                        vol_d[v]  = vol_q[v];
                    end
                end else if (ev_on_q && age_q[v] != 8'hFF) begin
                    age_d[v] = age_q[v] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_q   <= ACCEPT;
            live_q    <= 1'b0;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_tgt_q  <= '0;
            hit_q     <= 1'b0;
            retrig_q  <= 1'b0;
            idx_q     <= '0;
            for (int v = 0; v < VOICES; v++) begin
                note_q[v] <= '0;
                st_q[v]   <= IDLE;
                vol_q[v]  <= '0;
                tgt_q[v]  <= '0;
                age_q[v]  <= '0;
                freq_q[v] <= '0;
            end
        end else begin
            alloc_q   <= alloc_d;
            live_q    <= 1'b1;
            ev_on_q   <= ev_on_d;
            ev_note_q <= ev_note_d;
            ev_tgt_q  <= ev_tgt_d;
            hit_q     <= hit_d;
            retrig_q  <= retrig_d;
            idx_q     <= idx_d;
            note_q    <= note_d;
            st_q      <= st_d;
            vol_q     <= vol_d;
            tgt_q     <= tgt_d;
            age_q     <= age_d;
            freq_q    <= freq_d;
        end
    end

    always_comb begin
        frequencies   = '0;
        voice_volumes = '0;
        voice_active  = '0;
        for (int v = 0; v < VOICES; v++) begin
            frequencies[v*FREQ_W +: FREQ_W] = freq_q[v];
            voice_volumes[v*VOL_W +: VOL_W] = vol_q[v];
            voice_active[v]                 = (st_q[v] != IDLE);
        end
    end

endmodule

// File: tb/tb_synth_voice_allocator.sv
// Directed bench for synth_voice_allocator (4 voices): vector table plus handshake,
// tick/apply collision and asynchronous reset sequences.
module tb_synth_voice_allocator;

    logic        clk;
    logic        reset_n;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_note_on;
    logic [6:0]  ev_note;
    logic [6:0]  ev_velocity;
    logic        env_tick;
    logic [71:0] frequencies;
    logic [31:0] voice_volumes;
    logic [3:0]  voice_active;

    int n_cmp;
    int n_bad;

    synth_voice_allocator #(
        .VOICES       (4),
        .ATTACK_STEP  (8),
        .RELEASE_STEP (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_note_on    (ev_note_on),
        .ev_note       (ev_note),
        .ev_velocity   (ev_velocity),
        .env_tick      (env_tick),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .voice_active  (voice_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_ev;
        logic       on;
        logic [6:0] note;
        logic [6:0] vel;
        int         ticks;
        int         v;
        int         freq;
        int         vol;
        logic [3:0] act;
    } vec_t;

    vec_t tbl [18];

    function automatic int fq(input int v);
        return int'(frequencies[v*18 +: 18]);
    endfunction

    function automatic int vl(input int v);
        return int'(voice_volumes[v*8 +: 8]);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            env_tick = 1'b1;
            @(negedge clk);
            env_tick = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge where the event's effect is visible.
    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int guard;
        guard       = 0;
        ev_valid    = 1'b1;
        ev_note_on  = on;
        ev_note     = note;
        ev_velocity = vel;
        while (!ev_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ev_ready) chk("ready_timeout", int'(ev_ready), 1);
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready_low", int'(ev_ready), 0);
        chk("rst_freq_zero", int'(frequencies == '0), 1);
        chk("rst_vol_zero", int'(voice_volumes), 0);
        chk("rst_active_zero", int'(voice_active), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", int'(ev_ready), 1);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset_n     = 1'b0;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_note     = '0;
        ev_velocity = '0;
        env_tick    = 1'b0;

        //          ev    on    note    vel     tk  v  freq   vol  active
        tbl[0]  = '{1'b1, 1'b1, 7'd60,  7'd64,  0,  0, 4186,  0,   4'b0001};
        tbl[1]  = '{1'b0, 1'b0, 7'd0,   7'd0,   1,  0, 4186,  8,   4'b0001};
        tbl[2]  = '{1'b0, 1'b0, 7'd0,   7'd0,   15, 0, 4186,  128, 4'b0001};
        tbl[3]  = '{1'b0, 1'b0, 7'd0,   7'd0,   5,  0, 4186,  128, 4'b0001};
        tbl[4]  = '{1'b1, 1'b1, 7'd69,  7'd127, 0,  1, 7040,  0,   4'b0011};
        tbl[5]  = '{1'b0, 1'b0, 7'd0,   7'd0,   32, 1, 7040,  254, 4'b0011};
        tbl[6]  = '{1'b1, 1'b0, 7'd69,  7'd0,   1,  1, 7040,  250, 4'b0011};
        tbl[7]  = '{1'b0, 1'b0, 7'd0,   7'd0,   62, 1, 7040,  2,   4'b0011};
        tbl[8]  = '{1'b0, 1'b0, 7'd0,   7'd0,   1,  1, 7040,  0,   4'b0001};
        tbl[9]  = '{1'b1, 1'b1, 7'd60,  7'd100, 0,  0, 4186,  128, 4'b0001};
        tbl[10] = '{1'b0, 1'b0, 7'd0,   7'd0,   1,  0, 4186,  136, 4'b0001};
        tbl[11] = '{1'b1, 1'b1, 7'd60,  7'd0,   1,  0, 4186,  132, 4'b0001};
        tbl[12] = '{1'b1, 1'b1, 7'd62,  7'd40,  0,  1, 4698,  0,   4'b0011};
        tbl[13] = '{1'b1, 1'b1, 7'd64,  7'd40,  0,  2, 5274,  0,   4'b0111};
        tbl[14] = '{1'b1, 1'b1, 7'd65,  7'd40,  0,  3, 5587,  0,   4'b1111};
        tbl[15] = '{1'b1, 1'b1, 7'd67,  7'd50,  0,  0, 6271,  0,   4'b1111};
        tbl[16] = '{1'b1, 1'b0, 7'd99,  7'd0,   0,  0, 6271,  0,   4'b1111};
        tbl[17] = '{1'b1, 1'b0, 7'd62,  7'd0,   1,  1, 4698,  0,   4'b1101};

        do_reset();

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].do_ev) send(tbl[i].on, tbl[i].note, tbl[i].vel);
            tick(tbl[i].ticks);
            chk($sformatf("vec%0d_freq", i), fq(tbl[i].v), tbl[i].freq);
            chk($sformatf("vec%0d_vol", i), vl(tbl[i].v), tbl[i].vol);
            chk($sformatf("vec%0d_active", i), int'(voice_active), int'(tbl[i].act));
        end

        // ev_valid held high: ready must recur every third cycle.
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_note     = 7'd60;
        ev_velocity = 7'd64;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("stream_ready_c%0d", i), int'(ev_ready), (i % 3 == 0) ? 1 : 0);
            @(negedge clk);
        end
        ev_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_active", int'(voice_active), 4'b1111);
        chk("stream_v1_freq", fq(1), 4186);
        chk("stream_v1_vol", vl(1), 0);

        // env_tick coincident with APPLY: only the applied voice skips the tick.
        do_reset();
        send(1'b1, 7'd60, 7'd64);
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_note     = 7'd62;
        ev_velocity = 7'd64;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        @(negedge clk);
        env_tick = 1'b1;
        @(negedge clk);
        env_tick = 1'b0;
        chk("coll_v0_vol", vl(0), 8);
        chk("coll_v1_vol", vl(1), 0);
        chk("coll_v1_freq", fq(1), 4698);
        chk("coll_active", int'(voice_active), 4'b0011);
        tick(1);
        chk("coll_v0_vol2", vl(0), 16);
        chk("coll_v1_vol2", vl(1), 8);

        // Reset while an event sits in SEARCH.
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_note     = 7'd64;
        ev_velocity = 7'd64;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("srch_rst_freq", int'(frequencies == '0), 1);
        chk("srch_rst_vol", int'(voice_volumes), 0);
        chk("srch_rst_active", int'(voice_active), 0);
        chk("srch_rst_ready", int'(ev_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("srch_rst_dropped_active", int'(voice_active), 0);
        chk("srch_rst_dropped_freq", int'(frequencies == '0), 1);
        chk("srch_rst_ready_back", int'(ev_ready), 1);

        // Reset while a voice is releasing.
        send(1'b1, 7'd60, 7'd64);
        tick(4);
        send(1'b0, 7'd60, 7'd0);
        tick(2);
        chk("rel_v0_vol", vl(0), 24);
        chk("rel_active", int'(voice_active), 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        chk("rel_rst_vol", int'(voice_volumes), 0);
        chk("rel_rst_active", int'(voice_active), 0);
        chk("rel_rst_freq", int'(frequencies == '0), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Frequency range extremes.
        send(1'b1, 7'd0, 7'd10);
        chk("note0_freq", fq(0), 130);
        send(1'b1, 7'd127, 7'd10);
        chk("note127_freq", fq(1), 200701);
        chk("extreme_active", int'(voice_active), 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
